// File: rtl/adam_apb_initiator_pkg.sv
// Shared types and constants for the APB initiator: state encoding, default
// geometry and the command/response payload records at default widths.
package adam_apb_initiator_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_STRB_WIDTH = DEFAULT_DATA_WIDTH / 8;
  localparam int unsigned DEFAULT_TIMEOUT    = 256;

  localparam int unsigned STATE_WIDTH = 3;
  typedef logic [STATE_WIDTH-1:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t SETUP  = 3'd1;
  localparam state_t ACCESS = 3'd2;
  localparam state_t RESP   = 3'd3;
  localparam state_t PAUSED = 3'd4;

  typedef struct packed {
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    logic                          write;
    logic [DEFAULT_DATA_WIDTH-1:0] wdata;
    logic [DEFAULT_STRB_WIDTH-1:0] strb;
  } cmd_t;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] rdata;
    logic                          err;
  } rsp_t;

  // Strobes only carry meaning on writes; reads always present zero.
  function automatic logic [DEFAULT_STRB_WIDTH-1:0] apb_strb(
    input logic                          write,
    input logic [DEFAULT_STRB_WIDTH-1:0] strb
  );
    return write ? strb : '0;
  endfunction

endpackage

// File: rtl/adam_apb_watchdog.sv
// Saturating ACCESS-wait counter; flags the TIMEOUT-th consecutive cycle
// without pready so the transfer can be abandoned at the end of that cycle.
module adam_apb_watchdog
  import adam_apb_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired_c = enable && (count >= LAST);

endmodule

// File: rtl/adam_apb_initiator.sv
// APB requester: valid/ready command in, SETUP/ACCESS transfer out, response
// returned on a valid/ready stream; parks the bus on pause between transfers.
module adam_apb_initiator
  import adam_apb_initiator_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pause_req,
  output logic                    pause_ack,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  output logic                    psel,
  output logic                    penable,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] strb;
  } apb_req_t;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } rsp_rec_t;

  state_t   state, next_state;
  apb_req_t req_q, req_d;
  rsp_rec_t rsp_q, rsp_d;
  logic     psel_d, penable_d, pause_ack_d;
  logic     run_q;
  logic     wd_clear, wd_enable, wd_expired;

  // run_q keeps cmd_ready low while reset is asserted and for the first edge after.
  assign cmd_ready = (state == IDLE) && !pause_req && run_q;
  assign wd_clear  = cmd_valid && cmd_ready;
  assign wd_enable = (state == ACCESS) && !pready;

  adam_apb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (wd_clear),
    .enable    (wd_enable),
    .expired_c (wd_expired)
  );

  always_comb begin
    next_state = state;
    req_d      = req_q;
    rsp_d      = rsp_q;
    psel_d     = psel;
    penable_d  = penable;
    case (state)
      IDLE: begin
        if (pause_req) begin
          next_state = PAUSED;
        end else if (cmd_valid && cmd_ready) begin
          next_state  = SETUP;
          req_d.addr  = cmd_addr;
          req_d.write = cmd_write;
          req_d.wdata = cmd_wdata;
          req_d.strb  = cmd_write ? cmd_strb : '0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
        end
      end
      SETUP: begin
        next_state = ACCESS;
        penable_d  = 1'b1;
      end
      ACCESS: begin
        // A timed-out transfer reports an error with no data.
        if (pready || wd_expired) begin
          next_state  = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_d.valid = 1'b1;
          rsp_d.err   = pready ? pslverr : 1'b1;
          rsp_d.rdata = (pready && !req_q.write) ? prdata : '0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          next_state  = IDLE;
          rsp_d.valid = 1'b0;
        end
      end
      PAUSED: begin
        if (!pause_req) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        psel_d     = 1'b0;
        penable_d  = 1'b0;
      end
    endcase
    pause_ack_d = (next_state == PAUSED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_q     <= '0;
      rsp_q     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pause_ack <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state     <= next_state;
      req_q     <= req_d;
      rsp_q     <= rsp_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pause_ack <= pause_ack_d;
      run_q     <= 1'b1;
    end
  end

  assign paddr     = req_q.addr;
  assign pwrite    = req_q.write;
  assign pwdata    = req_q.wdata;
  assign pstrb     = req_q.strb;
  assign pprot     = 3'b000;
  assign rsp_valid = rsp_q.valid;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_err   = rsp_q.err;

endmodule
